sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 135 +++++++++++++
 tb/tb_sprite_blitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite mover: erases the sprite's previous tile and draws its new one, one pixel per cycle.
// Define SPRITE_BLITTER_TRANSPARENT_EN so that zero shape bits are skipped instead of written as BG.
module sprite_blitter #(
    parameter int unsigned      SIZE  = 5,
    parameter int unsigned      X_W   = 8,
    parameter int unsigned      Y_W   = 7,
    parameter int unsigned      COL_W = 3,
    parameter logic [COL_W-1:0] BG    = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 hide,
    input  logic [X_W-1:0]       tile_x,
    input  logic [Y_W-1:0]       tile_y,
    input  logic [SIZE*SIZE-1:0] shape,
    input  logic [COL_W-1:0]     colour,
    output logic                 plot,
    output logic [X_W-1:0]       x_out,
    output logic [Y_W-1:0]       y_out,
    output logic [COL_W-1:0]     col_out,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned NP = SIZE * SIZE;
    localparam int unsigned CW = $clog2(SIZE);
    localparam int unsigned IW = $clog2(NP);
    localparam logic [X_W-1:0] SIZE_X = X_W'(SIZE);
    localparam logic [Y_W-1:0] SIZE_Y = Y_W'(SIZE);

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_t;

    state_t           state_q;
    logic [CW-1:0]    row_q, col_q;
    logic             valid_q;
    logic [X_W-1:0]   prev_x_q, lat_x_q;
    logic [Y_W-1:0]   prev_y_q, lat_y_q;
    logic [NP-1:0]    lat_shape_q;
    logic [COL_W-1:0] lat_colour_q;
    logic             lat_hide_q;

    logic             col_last, scan_last;
    logic [IW-1:0]    pix_idx, bit_idx;
    logic             shape_bit;

    assign col_last  = (col_q == CW'(SIZE - 1));
    assign scan_last = col_last && (row_q == CW'(SIZE - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            valid_q      <= 1'b0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            lat_x_q      <= '0;
            lat_y_q      <= '0;
            lat_shape_q  <= '0;
            lat_colour_q <= '0;
            lat_hide_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        lat_x_q      <= tile_x;
                        lat_y_q      <= tile_y;
                        lat_shape_q  <= shape;
                        lat_colour_q <= colour;
                        lat_hide_q   <= hide;
                        if (valid_q)   state_q <= StErase;
                        else if (hide) state_q <= StDone;
                        else           state_q <= StDraw;
                    end
                end
                StErase, StDraw: begin
                    if (scan_last) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= (state_q == StErase && !lat_hide_q) ? StDraw : StDone;
                    end else if (col_last) begin
                        col_q <= '0;
                        row_q <= row_q + CW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                StDone: begin
                    if (lat_hide_q) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q  <= 1'b1;
                        prev_x_q <= lat_x_q;
                        prev_y_q <= lat_y_q;
                    end
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Shape MSB is the top-left pixel, scanned row-major.
    assign pix_idx   = IW'(row_q) * IW'(SIZE) + IW'(col_q);
    assign bit_idx   = IW'(NP - 1) - pix_idx;
    assign shape_bit = lat_shape_q[bit_idx];

    always_comb begin
        plot    = 1'b0;
        x_out   = '0;
        y_out   = '0;
        col_out = BG;
        unique case (state_q)
            StErase: begin
                plot  = 1'b1;
                x_out = prev_x_q * SIZE_X + X_W'(col_q);
                y_out = prev_y_q * SIZE_Y + Y_W'(row_q);
            end
            StDraw: begin
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
                plot    = shape_bit;
`else
                plot    = 1'b1;
`endif
                x_out   = lat_x_q * SIZE_X + X_W'(col_q);
                y_out   = lat_y_q * SIZE_Y + Y_W'(row_q);
                col_out = shape_bit ? lat_colour_q : BG;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed vector table plus random operations,
// every cycle compared against a pixel-list reference model.
module tb_sprite_blitter;
    localparam int SIZE = 5;
    localparam int NP   = SIZE * SIZE;
    localparam logic [2:0] BG = 3'd0;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          hide_in = 1'b0;
    logic [7:0]    tile_x = '0;
    logic [6:0]    tile_y = '0;
    logic [NP-1:0] shape = '0;
    logic [2:0]    colour = '0;
    logic          plot, busy, done;
    logic [7:0]    x_out;
    logic [6:0]    y_out;
    logic [2:0]    col_out;

    sprite_blitter #(.SIZE(SIZE), .X_W(8), .Y_W(7), .COL_W(3), .BG(BG)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .hide    (hide_in),
        .tile_x  (tile_x),
        .tile_y  (tile_y),
        .shape   (shape),
        .colour  (colour),
        .plot    (plot),
        .x_out   (x_out),
        .y_out   (y_out),
        .col_out (col_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       busy;
        logic       done;
        logic       chk_xy;
    } exp_t;

    typedef struct {
        logic          hide;
        int            tx, ty;
        logic [NP-1:0] shape;
        int            colour;
        int            ign_at, rst_at;
        int            exp_plots, exp_done;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model state: what the screen currently holds.
    bit m_valid = 0;
    int m_px = 0, m_py = 0;

    function automatic int draw_plots(input logic [NP-1:0] s);
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
        return $countones(s);
`else
        return (s === s) ? NP : 0;
`endif
    endfunction

    function automatic exp_t idle_exp(input logic chk);
        exp_t e;
        e.plot = 0; e.x = 0; e.y = 0; e.col = BG; e.busy = 0; e.done = 0; e.chk_xy = chk;
        return e;
    endfunction

    task automatic check_cycle(input string nm, input exp_t e);
        bit bad;
        n_checks++;
        bad = (plot !== e.plot) || (busy !== e.busy) || (done !== e.done);
        if (e.chk_xy) bad = bad || (x_out !== e.x) || (y_out !== e.y) || (col_out !== e.col);
        if (bad)
            $display("FAIL %s: plot/x/y/col/busy/done got %0d/%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d/%0d",
                     nm, plot, x_out, y_out, col_out, busy, done,
                     e.plot, e.x, e.y, e.col, e.busy, e.done);
        else n_pass++;
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) $display("FAIL %s: got %0d want %0d", nm, got, want);
        else n_pass++;
    endtask

    // Expected per-cycle output list for one accepted start.
    task automatic build(input logic hd, input int tx, input int ty, input logic [NP-1:0] s,
                         input int c);
        exp_t e;
        exp_q.delete();
        if (m_valid) begin
            for (int p = 0; p < NP; p++) begin
                e.plot = 1; e.busy = 1; e.done = 0; e.chk_xy = 1; e.col = BG;
                e.x = 8'((m_px * SIZE + p % SIZE) % 256);
                e.y = 7'((m_py * SIZE + p / SIZE) % 128);
                exp_q.push_back(e);
            end
        end
        if (!hd) begin
            for (int p = 0; p < NP; p++) begin
                logic b;
                b = s[NP-1-p];
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
                e.plot = b;
`else
                e.plot = 1;
`endif
                e.busy = 1; e.done = 0; e.chk_xy = 1;
                e.col = b ? 3'(c) : BG;
                e.x = 8'((tx * SIZE + p % SIZE) % 256);
                e.y = 7'((ty * SIZE + p / SIZE) % 128);
                exp_q.push_back(e);
            end
        end
        e = idle_exp(0);
        e.busy = 1; e.done = 1;
        exp_q.push_back(e);
    endtask

    task automatic do_op(input string nm, input vec_t v);
        int plots = 0;
        int done_at = -1;
        bit aborted = 0;
        build(v.hide, v.tx, v.ty, v.shape, v.colour);
        @(negedge clock);
        start = 1; hide_in = v.hide; tile_x = 8'(v.tx); tile_y = 7'(v.ty);
        shape = v.shape; colour = 3'(v.colour);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            check_cycle(nm, exp_q[i]);
            if (plot === 1'b1) plots++;
            if (done === 1'b1 && done_at < 0) done_at = i + 1;
            start = (i == v.ign_at);
            if (i == v.ign_at) begin
                hide_in = ~v.hide; tile_x = 8'(v.tx + 1); shape = ~v.shape;
            end
            if (i == v.rst_at) begin
                reset_n = 0;
                @(negedge clock);
                reset_n = 1;
                check_cycle({nm, "_rst"}, idle_exp(1));
                m_valid = 0; m_px = 0; m_py = 0;
                aborted = 1;
                break;
            end
        end
        start = 0;
        if (!aborted) begin
            if (v.hide) m_valid = 0;
            else begin m_valid = 1; m_px = v.tx; m_py = v.ty; end
            if (v.exp_plots >= 0) check_int({nm, "_plots"}, plots, v.exp_plots);
            if (v.exp_done >= 0) check_int({nm, "_done_cycle"}, done_at, v.exp_done);
        end
        @(negedge clock);
        check_cycle({nm, "_idle"}, idle_exp(0));
    endtask

    vec_t vecs[12];

    initial begin
        vec_t r;
        vecs[0]  = '{0, 2, 3, 25'h1FFFFFF, 6, -1, -1, draw_plots(25'h1FFFFFF), 26};
        vecs[1]  = '{0, 3, 3, 25'h1F8C63F, 6, -1, -1, NP + draw_plots(25'h1F8C63F), 51};
        vecs[2]  = '{0, 1, 1, 25'h0AAAAAA, 3, 10, -1, NP + draw_plots(25'h0AAAAAA), 51};
        vecs[3]  = '{1, 7, 7, 25'h0, 0, -1, -1, NP, 26};
        vecs[4]  = '{0, 4, 2, 25'h1555555, 5, -1, -1, draw_plots(25'h1555555), 26};
        vecs[5]  = '{0, 5, 5, 25'h1FFFFFF, 2, -1, NP + 12, -1, -1};
        vecs[6]  = '{0, 6, 6, 25'h1234567, 7, -1, -1, draw_plots(25'h1234567), 26};
        vecs[7]  = '{1, 9, 9, 25'h0, 1, -1, -1, NP, 26};
        vecs[8]  = '{1, 10, 10, 25'h0, 1, -1, -1, 0, 1};
        vecs[9]  = '{0, 255, 127, 25'h1FFFFFF, 4, -1, -1, draw_plots(25'h1FFFFFF), 26};
        vecs[10] = '{0, 0, 0, 25'h1FFFF00, 3, -1, -1, NP + draw_plots(25'h1FFFF00), 51};
        vecs[11] = '{0, 20, 12, 25'h1FFFF00, 5, 3, -1, NP + draw_plots(25'h1FFFF00), 51};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_cycle("reset_hold", idle_exp(1));
        reset_n = 1;
        @(negedge clock);
        check_cycle("after_reset", idle_exp(1));

        for (int k = 0; k < 12; k++) do_op($sformatf("vec%0d", k), vecs[k]);

        for (int k = 0; k < 20; k++) begin
            r.hide      = ($urandom_range(0, 3) == 0);
            r.tx        = int'($urandom_range(0, 255));
            r.ty        = int'($urandom_range(0, 127));
            r.shape     = NP'($urandom);
            r.colour    = int'($urandom_range(0, 7));
            r.ign_at    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : -1;
            r.rst_at    = -1;
            r.exp_plots = -1;
            r.exp_done  = (m_valid ? 1 : 0) + (r.hide ? 0 : 1);
            r.exp_done  = 1 + r.exp_done * NP;
            do_op($sformatf("rand%0d", k), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
